alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the datapath, succeeding the single-cycle 16-bit ALU. Operands and opcode are captured on a start handshake. Single-cycle ops complete in one cycle, and an optional iterative shift-add multiplier runs for WIDTH cycles. All outputs are registered, and the branch-compare result is a proper flop with full eq/ne/lt/le/gt/ge coverage.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_mul_seq.sv | 62 ++++++
 rtl/alu_mc.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared encodings for the multi-cycle ALU (alu_mc).
//
// Contents:
//   ALU_OP_*   4-bit opcode encoding (ADD..MUL); 9..15 are illegal.
//   ALU_CMP_*  3-bit unsigned compare condition encoding; 6..7 are illegal.
//   alu_state_t  controller FSM states (IDLE, EXEC, MUL).
//
// The MUL opcode and state exist in every build. Whether they are
// implemented is decided in alu_mc by the ALU_MUL_EN macro.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_OP_ADD  = 4'd0;
   localparam logic [3:0] ALU_OP_SUB  = 4'd1;
   localparam logic [3:0] ALU_OP_AND  = 4'd2;
   localparam logic [3:0] ALU_OP_OR   = 4'd3;
   localparam logic [3:0] ALU_OP_EPAR = 4'd4;
   localparam logic [3:0] ALU_OP_CMP  = 4'd5;
   localparam logic [3:0] ALU_OP_SHL  = 4'd6;
   localparam logic [3:0] ALU_OP_SHR  = 4'd7;
   localparam logic [3:0] ALU_OP_MUL  = 4'd8;

   localparam logic [2:0] ALU_CMP_EQ = 3'd0;
   localparam logic [2:0] ALU_CMP_NE = 3'd1;
   localparam logic [2:0] ALU_CMP_LT = 3'd2;
   localparam logic [2:0] ALU_CMP_LE = 3'd3;
   localparam logic [2:0] ALU_CMP_GT = 3'd4;
   localparam logic [2:0] ALU_CMP_GE = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MUL  = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq -- iterative shift-add unsigned multiplier.
//
// One multiplier bit is consumed per step. After WIDTH steps, product holds
// the full 2*WIDTH-bit product and done stays high until the next load.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high
//   load     in   capture a (multiplicand) and b (multiplier), clear the accumulator
//   step     in   advance one iteration (ignored once done is high)
//   a, b     in   WIDTH-bit operands, sampled on load
//   done     out  all WIDTH iterations have been performed
//   product  out  2*WIDTH-bit accumulator
// ---------------------------------------------------------------------------
module alu_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] STEPS = CW'(WIDTH);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;

   always_ff @(posedge clock) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         count  <= '0;
      end else if (step && (count != STEPS)) begin
         // Add the shifted multiplicand when the current multiplier LSB is set.
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + CW'(1);
      end
   end

   assign done    = (count == STEPS);
   assign product = acc;

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- parametrised multi-cycle ALU.
//
// Build option: define ALU_MUL_EN to build the iterative multiplier (op 8).
// Without it, op 8 completes in one cycle as an illegal op.
//
// Handshake: when busy=0, a cycle with start=1 is accepted at that clock
// edge. Operands, op and cond are latched there, and busy rises from the next
// cycle. When busy=1, start is ignored, not queued. The op ends with a single
// done pulse, and busy is already 0 in that same cycle, so a new start may be
// presented in the done cycle.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high
//   start      in   request, sampled only when busy=0
//   op[3:0]    in   ADD, SUB, AND, OR, EPAR, CMP, SHL, SHR, MUL (0..8)
//   cond[2:0]  in   unsigned CMP condition: eq, ne, lt, le, gt, ge (0..5)
//   a, b       in   operands; b[$clog2(WIDTH)-1:0] is the shift amount
//   busy       out  operation in flight
//   done       out  one-cycle pulse: result/carry/illegal are valid
//   result     out  registered result, held until the next done
//   carry      out  ADD carry, SUB borrow, MUL overflow; 0 otherwise
//   compres    out  CMP outcome, changed only by CMP
//   illegal    out  bad op or bad cond, updated on every done
//   fsm_state  out  controller state (alu_state_t encoding) for observation
// ---------------------------------------------------------------------------
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 16   // power of two, >= 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [2:0]       cond,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             compres,
   output logic             illegal,
   output logic [1:0]       fsm_state
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_t state;
   alu_state_t state_next;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       op_q;
   logic [2:0]       cond_q;

   logic             accept;
   logic             finish;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [SHW-1:0]   shamt;
   logic             cmp_hit;
   logic             cond_bad;

   logic [WIDTH-1:0] fin_result;
   logic             fin_carry;
   logic             fin_compres;
   logic             fin_illegal;

`ifdef ALU_MUL_EN
   logic               mul_load;
   logic               mul_step;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;
`endif

   assign accept    = (state == IDLE) && start;
   assign busy      = (state != IDLE);
   assign fsm_state = state;

   // ------------------------------------------------------------------
   // Controller FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = EXEC;
`ifdef ALU_MUL_EN
               if (op == ALU_OP_MUL) begin
                  state_next = MUL;
               end
`endif
            end
         end
         EXEC: state_next = IDLE;
`ifdef ALU_MUL_EN
         MUL: begin
            if (mul_done) begin
               state_next = IDLE;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // The op completes when EXEC runs, or in the first MUL cycle after the
   // multiplier has finished all of its iterations.
   always_comb begin
      finish = (state == EXEC);
`ifdef ALU_MUL_EN
      if ((state == MUL) && mul_done) begin
         finish = 1'b1;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Operand capture: the op only ever uses these latched copies.
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         cond_q <= '0;
      end else if (accept) begin
         a_q    <= a;
         b_q    <= b;
         op_q   <= op;
         cond_q <= cond;
      end
   end

`ifdef ALU_MUL_EN
   // The multiplier loads straight from the input ports at the accept edge,
   // so its first iteration runs in the first MUL cycle.
   assign mul_load = accept && (op == ALU_OP_MUL);
   assign mul_step = (state == MUL) && !mul_done;

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clock   (clock),
      .reset   (reset),
      .load    (mul_load),
      .step    (mul_step),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   // ------------------------------------------------------------------
   // Result decode from the latched operands
   // ------------------------------------------------------------------
   always_comb begin
      sum   = {1'b0, a_q} + {1'b0, b_q};
      // The MSB of the WIDTH+1-bit difference is the borrow, set when a < b.
      diff  = {1'b0, a_q} - {1'b0, b_q};
      shamt = b_q[SHW-1:0];

      cmp_hit  = 1'b0;
      cond_bad = 1'b0;
      case (cond_q)
         ALU_CMP_EQ: cmp_hit = (a_q == b_q);
         ALU_CMP_NE: cmp_hit = (a_q != b_q);
         ALU_CMP_LT: cmp_hit = (a_q <  b_q);
         ALU_CMP_LE: cmp_hit = (a_q <= b_q);
         ALU_CMP_GT: cmp_hit = (a_q >  b_q);
         ALU_CMP_GE: cmp_hit = (a_q >= b_q);
         default:    cond_bad = 1'b1;
      endcase

      fin_result  = '0;
      fin_carry   = 1'b0;
      fin_compres = compres;
      fin_illegal = 1'b0;
      case (op_q)
         ALU_OP_ADD: begin
            fin_result = sum[WIDTH-1:0];
            fin_carry  = sum[WIDTH];
         end
         ALU_OP_SUB: begin
            fin_result = diff[WIDTH-1:0];
            fin_carry  = diff[WIDTH];
         end
         ALU_OP_AND:  fin_result = a_q & b_q;
         ALU_OP_OR:   fin_result = a_q | b_q;
         ALU_OP_EPAR: fin_result = {{(WIDTH-1){1'b0}}, ^a_q};
         ALU_OP_CMP: begin
            // cmp_hit is 0 for a bad cond, so compres is cleared in that case.
            fin_compres = cmp_hit;
            fin_illegal = cond_bad;
         end
         ALU_OP_SHL: fin_result = a_q << shamt;
         ALU_OP_SHR: fin_result = a_q >> shamt;
         default:    fin_illegal = 1'b1;
      endcase

`ifdef ALU_MUL_EN
      if (state == MUL) begin
         fin_result  = mul_product[WIDTH-1:0];
         fin_carry   = |mul_product[2*WIDTH-1:WIDTH];
         fin_compres = compres;
         fin_illegal = 1'b0;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         done    <= 1'b0;
         result  <= '0;
         carry   <= 1'b0;
         compres <= 1'b0;
         illegal <= 1'b0;
      end else begin
         done <= finish;
         if (finish) begin
            result  <= fin_result;
            carry   <= fin_carry;
            compres <= fin_compres;
            illegal <= fin_illegal;
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- directed self-checking bench for alu_mc (WIDTH=16).
// Expected MUL behaviour follows the ALU_MUL_EN build option.
// ---------------------------------------------------------------------------
module tb_alu_mc;
   import alu_pkg::*;

   localparam int WIDTH = 16;

   logic             clock;
   logic             reset;
   logic             start;
   logic [3:0]       op;
   logic [2:0]       cond;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             compres;
   logic             illegal;
   logic [1:0]       fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mc #(.WIDTH(WIDTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .cond      (cond),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry     (carry),
      .compres   (compres),
      .illegal   (illegal),
      .fsm_state (fsm_state)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   // Issue one op and return once done is seen, or when the cycle budget runs
   // out. lat counts the clock edges from the accept edge to the done cycle.
   // The inputs are scrambled right after the accept edge to show that the
   // op works only from the latched copies.
   task automatic run_op(input logic [3:0] o, input logic [2:0] c,
                         input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output int lat, output logic bsy);
      @(negedge clock);
      op = o; cond = c; a = x; b = y; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; op = 4'd15; cond = 3'd7; a = ~x; b = ~y;
      bsy = busy;
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = '0; cond = '0; a = '0; b = '0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", carry); end
      n_checks++; if (compres !== 1'b0) begin n_fail++; $display("FAIL reset_compres: got %b want 0", compres); end
      n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
      n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_add;
      int lat; logic bsy;
      run_op(4'd0, 3'd0, 16'hFFFF, 16'h0001, lat, bsy);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
      n_checks++; if (bsy !== 1'b1) begin n_fail++; $display("FAIL add_busy_exec: got %b want 1", bsy); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_done: got %b want 0", busy); end
      n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL add_wrap_result: got %h want 0000", result); end
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL add_wrap_carry: got %b want 1", carry); end
      n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL add_illegal: got %b want 0", illegal); end
      @(posedge clock); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done); end
      run_op(4'd0, 3'd0, 16'h1234, 16'h4321, lat, bsy);
      n_checks++; if (result !== 16'h5555) begin n_fail++; $display("FAIL add_result: got %h want 5555", result); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL add_carry: got %b want 0", carry); end
   endtask

   task automatic test_sub;
      int lat; logic bsy;
      run_op(4'd1, 3'd0, 16'h0003, 16'h0005, lat, bsy);
      n_checks++; if (result !== 16'hFFFE) begin n_fail++; $display("FAIL sub_borrow_result: got %h want fffe", result); end
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL sub_borrow_carry: got %b want 1", carry); end
      run_op(4'd1, 3'd0, 16'h0005, 16'h0003, lat, bsy);
      n_checks++; if (result !== 16'h0002) begin n_fail++; $display("FAIL sub_result: got %h want 0002", result); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL sub_carry: got %b want 0", carry); end
   endtask

   task automatic test_logic_shift;
      int lat; logic bsy;
      run_op(4'd2, 3'd0, 16'hF0F0, 16'hFF00, lat, bsy);
      n_checks++; if (result !== 16'hF000) begin n_fail++; $display("FAIL and_result: got %h want f000", result); end
      run_op(4'd3, 3'd0, 16'hF0F0, 16'hFF00, lat, bsy);
      n_checks++; if (result !== 16'hFFF0) begin n_fail++; $display("FAIL or_result: got %h want fff0", result); end
      run_op(4'd4, 3'd0, 16'h0007, 16'h0000, lat, bsy);
      n_checks++; if (result !== 16'h0001) begin n_fail++; $display("FAIL epar_odd: got %h want 0001", result); end
      run_op(4'd4, 3'd0, 16'h0003, 16'hFFFF, lat, bsy);
      n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL epar_even: got %h want 0000", result); end
      run_op(4'd6, 3'd0, 16'h0001, 16'h0014, lat, bsy);
      n_checks++; if (result !== 16'h0010) begin n_fail++; $display("FAIL shl_amt_lowbits: got %h want 0010", result); end
      run_op(4'd6, 3'd0, 16'h00FF, 16'h0008, lat, bsy);
      n_checks++; if (result !== 16'hFF00) begin n_fail++; $display("FAIL shl_result: got %h want ff00", result); end
      run_op(4'd7, 3'd0, 16'h8000, 16'h000F, lat, bsy);
      n_checks++; if (result !== 16'h0001) begin n_fail++; $display("FAIL shr_result: got %h want 0001", result); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL shr_carry: got %b want 0", carry); end
   endtask

   task automatic test_cmp;
      int lat; logic bsy;
      logic [2:0]  cv [0:5];
      logic [15:0] av [0:5];
      logic [15:0] bv [0:5];
      logic        ev [0:5];
      cv = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd2, 3'd5};
      av = '{16'h0009, 16'h0004, 16'h0007, 16'h0003, 16'h8000, 16'h0008};
      bv = '{16'h0009, 16'h0004, 16'h0007, 16'h0007, 16'h0001, 16'h0007};
      ev = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      run_op(4'd5, 3'd2, 16'h0005, 16'h0007, lat, bsy);
      n_checks++; if (compres !== 1'b1) begin n_fail++; $display("FAIL cmp_lt_compres: got %b want 1", compres); end
      n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL cmp_result: got %h want 0000", result); end
      run_op(4'd0, 3'd0, 16'h0001, 16'h0001, lat, bsy);
      n_checks++; if (compres !== 1'b1) begin n_fail++; $display("FAIL cmp_hold_after_add: got %b want 1", compres); end
      run_op(4'd5, 3'd6, 16'h0005, 16'h0007, lat, bsy);
      n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL cmp_badcond_illegal: got %b want 1", illegal); end
      n_checks++; if (compres !== 1'b0) begin n_fail++; $display("FAIL cmp_badcond_compres: got %b want 0", compres); end
      for (int i = 0; i < 6; i++) begin
         run_op(4'd5, cv[i], av[i], bv[i], lat, bsy);
         n_checks++;
         if (compres !== ev[i] || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_table[%0d]: compres=%b illegal=%b want compres=%b illegal=0", i, compres, illegal, ev[i]);
         end
      end
   endtask

   task automatic test_illegal_op;
      int lat; logic bsy;
      run_op(4'd0, 3'd0, 16'hFFFF, 16'h0003, lat, bsy);
      n_checks++; if (result !== 16'h0002 || carry !== 1'b1) begin n_fail++; $display("FAIL illop_setup: got %h/%b want 0002/1", result, carry); end
      run_op(4'd12, 3'd0, 16'h1234, 16'h5678, lat, bsy);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL illop_latency: got %0d want 1", lat); end
      n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illop_illegal: got %b want 1", illegal); end
      n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL illop_result: got %h want 0000", result); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL illop_carry: got %b want 0", carry); end
      n_checks++; if (compres !== 1'b1) begin n_fail++; $display("FAIL illop_compres_hold: got %b want 1", compres); end
      run_op(4'd0, 3'd0, 16'h0002, 16'h0002, lat, bsy);
      n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illop_clear: got %b want 0", illegal); end
      n_checks++; if (result !== 16'h0004) begin n_fail++; $display("FAIL illop_next_result: got %h want 0004", result); end
   endtask

   task automatic test_back_to_back;
      @(negedge clock);
      op = 4'd0; cond = 3'd0; a = 16'h0001; b = 16'h0002; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      n_checks++; if (done !== 1'b1 || result !== 16'h0003) begin n_fail++; $display("FAIL b2b_first: done=%b result=%h want 1/0003", done, result); end
      @(negedge clock);
      op = 4'd1; a = 16'h000A; b = 16'h0004; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got %b want 0", done); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
      @(posedge clock); #1;
      n_checks++; if (done !== 1'b1 || result !== 16'h0006) begin n_fail++; $display("FAIL b2b_second: done=%b result=%h want 1/0006", done, result); end
   endtask

   task automatic test_busy_drop;
      @(negedge clock);
      op = 4'd2; cond = 3'd0; a = 16'h000F; b = 16'h0003; start = 1'b1;
      @(posedge clock); #1;
      // Present a different request while busy; it must be dropped.
      op = 4'd3; a = 16'h00F0; b = 16'h000F; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      n_checks++; if (done !== 1'b1 || result !== 16'h0003) begin n_fail++; $display("FAIL drop_first: done=%b result=%h want 1/0003", done, result); end
      @(posedge clock); #1;
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_not_queued: done=%b busy=%b want 0/0", done, busy); end
      n_checks++; if (result !== 16'h0003) begin n_fail++; $display("FAIL drop_result_hold: got %h want 0003", result); end
   endtask

   task automatic test_reset_midop;
      int lat; logic bsy; logic saw_done;
      run_op(4'd5, 3'd0, 16'h0004, 16'h0004, lat, bsy);
      run_op(4'd0, 3'd0, 16'hFFFF, 16'h0002, lat, bsy);
      n_checks++; if (result !== 16'h0001 || carry !== 1'b1 || compres !== 1'b1) begin n_fail++; $display("FAIL rst_setup: %h/%b/%b want 0001/1/1", result, carry, compres); end
      @(negedge clock);
      op = 4'd1; a = 16'h0009; b = 16'h0001; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: done=%b busy=%b want 0/0", done, busy); end
      n_checks++; if (result !== 16'h0000 || carry !== 1'b0 || compres !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: %h/%b/%b/%b want 0000/0/0/0", result, carry, compres, illegal); end
      @(negedge clock);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (5) begin
         @(posedge clock); #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done: saw done=%b want 0", saw_done); end
   endtask

   task automatic test_mul;
      int lat; logic bsy;
`ifdef ALU_MUL_EN
      @(negedge clock);
      op = 4'd8; cond = 3'd0; a = 16'h0100; b = 16'h0101; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; op = 4'd15; a = 16'hFFFF; b = 16'hFFFF;
      n_checks++; if (fsm_state !== 2'd2) begin n_fail++; $display("FAIL mul_state: got %0d want 2", fsm_state); end
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (lat == 4) begin start = 1'b1; op = 4'd0; end else start = 1'b0;
         @(posedge clock); #1;
         lat++;
      end
      start = 1'b0;
      n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL mul_latency: got %0d want 17", lat); end
      n_checks++; if (result !== 16'h0100) begin n_fail++; $display("FAIL mul_result: got %h want 0100", result); end
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL mul_overflow: got %b want 1", carry); end
      n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL mul_illegal: got %b want 0", illegal); end
      @(posedge clock); #1;
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mul_drop: done=%b busy=%b want 0/0", done, busy); end
      run_op(4'd8, 3'd0, 16'h0003, 16'h0005, lat, bsy);
      n_checks++; if (lat !== 17 || result !== 16'h000F || carry !== 1'b0) begin n_fail++; $display("FAIL mul_small: lat=%0d result=%h carry=%b want 17/000f/0", lat, result, carry); end
`else
      run_op(4'd8, 3'd0, 16'h0100, 16'h0101, lat, bsy);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL mul_off_latency: got %0d want 1", lat); end
      n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL mul_off_illegal: got %b want 1", illegal); end
      n_checks++; if (result !== 16'h0000 || carry !== 1'b0) begin n_fail++; $display("FAIL mul_off_result: %h/%b want 0000/0", result, carry); end
`endif
   endtask

   task automatic test_mul_reset;
`ifdef ALU_MUL_EN
      logic saw_done;
      @(negedge clock);
      op = 4'd8; cond = 3'd0; a = 16'h0003; b = 16'h0007; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || fsm_state !== 2'd0) begin n_fail++; $display("FAIL mulrst_ctrl: done=%b busy=%b state=%0d want 0/0/0", done, busy, fsm_state); end
      n_checks++; if (result !== 16'h0000 || carry !== 1'b0 || compres !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL mulrst_outputs: %h/%b/%b/%b want all 0", result, carry, compres, illegal); end
      @(negedge clock);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (20) begin
         @(posedge clock); #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mulrst_no_done: saw done=%b want 0", saw_done); end
`endif
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic_shift();
      test_cmp();
      test_illegal_op();
      test_back_to_back();
      test_busy_drop();
      test_mul();
      test_reset_midop();
      test_mul_reset();
      repeat (2) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
